// File: rtl/ioports_responder_if.sv
// ----------------------------------------------------------------------------
// ioports_responder_if
// Byte-level link between the board UART and the I/O port responder.
//   rxready : one-cycle pulse, rxdata holds a freshly received byte
//   rxdata  : received byte
//   txready : high while the UART transmitter is idle
//   txen    : one-cycle pulse, load txdata and start a transmission
//   txdata  : byte to transmit
// The responder uses the slave modport; the UART side uses the master modport.
// ----------------------------------------------------------------------------
interface ioports_responder_if;
    logic       rxready;
    logic [7:0] rxdata;
    logic       txready;
    logic       txen;
    logic [7:0] txdata;

    modport slave (
        input  rxready,
        input  rxdata,
        input  txready,
        output txen,
        output txdata
    );

    modport master (
        output rxready,
        output rxdata,
        output txready,
        input  txen,
        input  txdata
    );
endinterface

// File: rtl/ioports_responder.sv
// ----------------------------------------------------------------------------
// ioports_responder
// Device-side end of the byte-serial I/O port protocol. Command bytes are
// {op[3:0], port[3:0]}: op 0x2 writes a 32-bit value (4 bytes, MSB first)
// into one of 16 output registers, op 0x3 returns a 32-bit snapshot of one of
// 16 input ports through the UART transmitter, MSB first. Other ops are
// ignored.
// Ports:
//   clock, reset_n : master clock, asynchronous active-low reset
//   uart           : UART byte link (rx pulse/data, tx ready/enable/data)
//   out_ports      : 16 x 32-bit write registers, port p at [32p+31:32p]
//   wr_strobe      : one-cycle pulse on bit p when port p is updated
//   in_ports       : 16 x 32-bit read sources, same packing as out_ports
//   busy           : high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module ioports_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned AUTOCLEAR_PORT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    ioports_responder_if.slave  uart,
    output logic [511:0]        out_ports,
    output logic [15:0]         wr_strobe,
    input  logic [511:0]        in_ports,
    output logic                busy
);
    localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  OP_WRITE = 4'b0010;
    localparam logic [3:0]  OP_READ  = 4'b0011;
    localparam logic [3:0]  AC_IDX   = 4'(AUTOCLEAR_PORT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_SEND,
        RD_WAITLO,
        RD_WAITHI
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        port_q, port_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       shift_q, shift_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       out_q [16];
    logic [31:0]       out_d [16];
    logic [15:0]       strobe_q, strobe_d;
    logic              txen_q, txen_d;
    logic [7:0]        txdata_q, txdata_d;

    logic [3:0]        rx_op;
    logic [3:0]        rx_port;

    assign rx_op   = uart.rxdata[7:4];
    assign rx_port = uart.rxdata[3:0];

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shift_d  = shift_q;
        tmo_d    = tmo_q;
        out_d    = out_q;
        strobe_d = '0;
        txen_d   = 1'b0;
        txdata_d = txdata_q;

        // The auto-clear port keeps a written value only while its strobe is high.
        if (strobe_q[AC_IDX]) begin
            out_d[AC_IDX] = '0;
        end

        case (state_q)
            IDLE: begin
                if (uart.rxready) begin
                    if (rx_op == OP_WRITE) begin
                        port_d  = rx_port;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = WR_DATA;
                    end else if (rx_op == OP_READ) begin
                        // Snapshot now so later in_ports changes cannot leak into the reply.
                        shift_d = in_ports[{rx_port, 5'b0} +: 32];
                        cnt_d   = '0;
                        state_d = RD_SEND;
                    end
                end
            end
            WR_DATA: begin
                if (uart.rxready) begin
                    acc_d = {acc_q[23:0], uart.rxdata};
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        out_d[port_q] = acc_d;
                        strobe_d      = 16'd1 << port_q;
                        state_d       = IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Stalled frame: drop it without touching out_ports.
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RD_SEND: begin
                if (uart.txready) begin
                    txdata_d = shift_q[31:24];
                    txen_d   = 1'b1;
                    state_d  = RD_WAITLO;
                end
            end
            RD_WAITLO: begin
                // Wait for the transmitter to acknowledge by going busy.
                if (!uart.txready) begin
                    state_d = RD_WAITHI;
                end
            end
            RD_WAITHI: begin
                if (uart.txready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? IDLE : RD_SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            port_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            strobe_q <= '0;
            txen_q   <= 1'b0;
            txdata_q <= '0;
            for (int p = 0; p < 16; p++) begin
                out_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            strobe_q <= strobe_d;
            txen_q   <= txen_d;
            txdata_q <= txdata_d;
            for (int p = 0; p < 16; p++) begin
                out_q[p] <= out_d[p];
            end
        end
    end

    // Pure datapath shift registers; always reloaded before use.
    always_ff @(posedge clock) begin
        acc_q   <= acc_d;
        shift_q <= shift_d;
    end

    for (genvar p = 0; p < 16; p++) begin : g_pack
        assign out_ports[32*p +: 32] = out_q[p];
    end

    assign wr_strobe   = strobe_q;
    assign uart.txen   = txen_q;
    assign uart.txdata = txdata_q;
    assign busy        = (state_q != IDLE);

endmodule
